// File: rtl/logic_op_pkg.sv
// rtl/logic_op_pkg.sv - op codes, FSM states and op classification for logic_op_unit
package logic_op_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOT  = 3'b100,
      OP_BUF  = 3'b101,
      OP_MUX  = 3'b110,
      OP_HOLD = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LOAD_A = 2'b01,
      LOAD_B = 2'b10,
      EXEC   = 2'b11
   } state_t;

   // Ops that never consume operand B, so the B load phase is skipped
   function automatic logic is_unary(op_t op);
      return (op == OP_NOT) || (op == OP_BUF) || (op == OP_HOLD);
   endfunction

endpackage

// File: rtl/logic_op_alu.sv
// rtl/logic_op_alu.sv - combinational WIDTH-bit evaluator for the eight logic op codes
module logic_op_alu
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mux_sel,
   input  logic [WIDTH-1:0] prev,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = prev;
      case (op_t'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         OP_MUX:  y = mux_sel ? b : a;
         OP_HOLD: y = prev;
         default: y = prev;
      endcase
   end

endmodule

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - serial-load logic op unit: FSM, operand shift registers, result register
// Optional LOGIC_OP_CHAIN_EN: chain=1 at start reuses the previous result as operand B.
module logic_op_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHIFT_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic               chain,
   input  logic               din_valid,
   input  logic [SHIFT_W-1:0] din,
   input  logic               mux_sel,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   localparam int BEATS = WIDTH / SHIFT_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_t             state_q, state_d;
   op_t                op_q;
   logic [WIDTH-1:0]   a_q, b_q, result_q, b_eff, alu_y;
   logic [CNT_W-1:0]   cnt_q;
   logic               done_q;
   logic               last_beat, shift_a, shift_b, use_prev;

`ifdef LOGIC_OP_CHAIN_EN
   logic chain_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         chain_q <= 1'b0;
      else if (state_q == IDLE && start)
         chain_q <= chain;
   end

   assign use_prev = chain_q && !is_unary(op_q);
`else
   logic unused_chain;
   assign unused_chain = chain;
   assign use_prev     = 1'b0;
`endif

   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD_A;
         LOAD_A:  if (din_valid && last_beat)
                     state_d = (is_unary(op_q) || use_prev) ? EXEC : LOAD_B;
         LOAD_B:  if (din_valid && last_beat) state_d = EXEC;
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // busy spans the done cycle, which is already back in IDLE
   always_comb begin
      shift_a = (state_q == LOAD_A) && din_valid;
      shift_b = (state_q == LOAD_B) && din_valid;
      busy    = (state_q != IDLE) || done_q;
   end

   assign b_eff = use_prev ? result_q : b_q;

   logic_op_alu #(.WIDTH(WIDTH)) u_alu (
      .op      (op_q),
      .a       (a_q),
      .b       (b_eff),
      .mux_sel (mux_sel),
      .prev    (result_q),
      .y       (alu_y)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= OP_AND;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == EXEC);
         if (state_q == IDLE && start)
            op_q <= op_t'(op);
         if (shift_a)
            a_q <= WIDTH'({a_q, din});
         if (shift_b)
            b_q <= WIDTH'({b_q, din});
         if (shift_a || shift_b)
            cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
         if (state_q == EXEC)
            result_q <= alu_y;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_logic_op_unit.sv
// tb/tb_logic_op_unit.sv - scoreboard bench for logic_op_unit with randomized ops and a reference model
module tb_logic_op_unit;

   localparam int W     = 8;
   localparam int S     = 2;
   localparam int BEATS = W / S;

   logic         clk = 1'b0;
   logic         reset, start, chain, din_valid, mux_sel;
   logic [2:0]   op;
   logic [S-1:0] din;
   logic         busy, done;
   logic [W-1:0] result;

   always #5 clk = ~clk;

   logic_op_unit #(.WIDTH(W), .SHIFT_W(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .chain     (chain),
      .din_valid (din_valid),
      .din       (din),
      .mux_sel   (mux_sel),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] sb[$];
   logic [W-1:0] mdl_res = '0;
   logic [W-1:0] held    = '0;
   bit           prev_done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input int code, input int a, input int b,
                                           input bit ms, input int prev);
      int m;
      int r;
      m = (1 << W) - 1;
      case (code)
         0:       r = a & b;
         1:       r = a | b;
         2:       r = a ^ b;
         3:       r = ~(a & b);
         4:       r = ~a;
         5:       r = a;
         6:       r = ms ? b : a;
         default: r = prev;
      endcase
      return W'(r & m);
   endfunction

   // Monitor: pops an expectation on every done pulse, otherwise result must hold
   always @(negedge clk) begin
      if (reset) begin
         held      = '0;
         prev_done = 1'b0;
      end else begin
         if (done) begin
            check("done_pulse_width", int'(prev_done), 0);
            if (sb.size() == 0)
               check("unexpected_done", 1, 0);
            else begin
               held = sb.pop_front();
               check("result", result, held);
            end
         end else
            check("result_held", result, held);
         prev_done = done;
      end
   end

   task automatic feed(input logic [W-1:0] v, input int mode);
      int n;
      for (int i = 0; i < BEATS; i++) begin
         n = 0;
         if (mode == 1 && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
         if (mode == 2 && i == 2) n = 3;
         for (int k = 0; k < n; k++) begin
            din_valid = 1'b0;
            din       = S'($urandom);
            start     = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            op        = 3'($urandom);
            @(posedge clk) #1;
            check("busy_stall", busy, 1);
         end
         start     = 1'b0;
         din_valid = 1'b1;
         din       = S'(v >> (W - S * (i + 1)));
         @(posedge clk) #1;
      end
      din_valid = 1'b0;
   endtask

   task automatic run_op(input int code, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ch, input bit ms, input int mode);
      bit           unary;
      bit           use_prev;
      logic [W-1:0] exp;
      unary    = (code == 4) || (code == 5) || (code == 7);
      use_prev = 1'b0;
`ifdef LOGIC_OP_CHAIN_EN
      use_prev = ch && !unary;
`endif
      exp = ref_op(code, a, use_prev ? mdl_res : b, ms, mdl_res);
      sb.push_back(exp);
      mdl_res = exp;
      start   = 1'b1;
      op      = 3'(code);
      chain   = ch;
      mux_sel = 1'($urandom);
      @(posedge clk) #1;
      start = 1'b0;
      op    = 3'($urandom);
      chain = 1'($urandom);
      check("busy_after_start", busy, 1);
      feed(a, mode);
      if (!unary && !use_prev) feed(b, (mode == 1) ? 1 : 0);
      mux_sel = ms;
      @(posedge clk) #1;
      check("done_latency", done, 1);
      check("busy_in_done", busy, 1);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; chain = 1'b0;
      din_valid = 1'b0; din = '0; mux_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      reset = 1'b0;
      @(posedge clk) #1;

      run_op(0, 8'hF0, 8'hAA, 0, 0, 0);
      run_op(4, 8'h3C, 8'h00, 0, 0, 0);
      run_op(6, 8'h0F, 8'hF0, 0, 1, 0);
      run_op(6, 8'h0F, 8'hF0, 0, 0, 0);
      run_op(7, 8'h99, 8'h66, 0, 0, 0);
      run_op(1, 8'h12, 8'h34, 0, 0, 2);

      // Reset mid-LOAD_B discards the in-flight op
      start = 1'b1; op = 3'd0;
      @(posedge clk) #1;
      start = 1'b0;
      feed(8'hFF, 0);
      din_valid = 1'b1; din = 2'b11;
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midload_reset_busy", busy, 0);
      check("midload_reset_done", done, 0);
      check("midload_reset_result", result, 0);
      din_valid = 1'b0;
      mdl_res = '0;
      @(posedge clk) #1;
      reset = 1'b0;
      @(posedge clk) #1;
      run_op(7, 8'hAB, 8'hCD, 0, 0, 0);
      run_op(2, 8'h5A, 8'h0F, 0, 0, 0);

      run_op(5, 8'h55, 8'h00, 0, 0, 0);
      run_op(2, 8'hFF, 8'h00, 1, 0, 0);

      for (int t = 0; t < 60; t++) begin
         run_op($urandom_range(0, 7), W'($urandom), W'($urandom),
                1'($urandom), 1'($urandom), 1);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk) #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
         end
      end

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
